// File: rtl/arbiter_pkg.sv
// ----------------------------------------------------------------------------
// arbiter_pkg
//
// Purpose:
//   Shared constants, types and helpers for the 4-way round-robin arbiter
//   (rr_arbiter_4) and its one-hot grant decoder (decoder_2_to_4).
//
// Contents:
//   N_REQ       number of requesters (4)
//   IDX_W       width of a requester index (2)
//   idx_t       requester index type
//   req_t       request / grant vector type
//   arb_state_t arbiter state encoding (S_IDLE, S_GRANT)
//   idx_add     mod-N_REQ index addition used by the rotating priority search
// ----------------------------------------------------------------------------
package arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [N_REQ-1:0] req_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arb_state_t;

    // N_REQ is a power of two, so plain truncating addition is the mod-N wrap
    // (3 + 1 -> 0).
    function automatic idx_t idx_add(input idx_t base, input idx_t offset);
        return idx_t'(base + offset);
    endfunction

endpackage : arbiter_pkg

// File: rtl/decoder_2_to_4.sv
// ----------------------------------------------------------------------------
// decoder_2_to_4
//
// Purpose:
//   Turns a 2-bit requester index into a one-hot 4-bit vector, gated by an
//   enable. Used by the arbiter to build the one-hot grant from the
//   registered grant index and grant-valid flag.
//
// Ports:
//   ena  in   1  enable; when low the output is all zero
//   in   in   2  index to decode
//   out  out  4  one-hot decode of 'in' when ena=1, else 4'b0000
// ----------------------------------------------------------------------------
module decoder_2_to_4
    import arbiter_pkg::*;
(
    input  logic             ena,
    input  logic [IDX_W-1:0] in,
    output logic [N_REQ-1:0] out
);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
        assign out[gi] = ena && (in == IDX_W'(gi));
    end

endmodule : decoder_2_to_4

// File: rtl/rr_arbiter_4.sv
// ----------------------------------------------------------------------------
// rr_arbiter_4
//
// Purpose:
//   Round-robin arbiter sharing one resource between 4 requesters.
//   Arbitration is registered (one edge from request to grant). A grant is
//   locked to its holder while the holder keeps its request high, up to
//   MAX_HOLD consecutive cycles; after that the grant is forced to rotate so
//   no requester starves. A holder that is the only requester is simply
//   regranted with a fresh hold count.
//
// Parameters:
//   MAX_HOLD   maximum consecutive cycles of one grant (>= 1)
//
// Ports:
//   clk        in   1  system clock, all state updates on posedge
//   rst        in   1  synchronous reset, active low
//   ena        in   1  arbiter enable; low = no new grants, current grant dropped
//   req        in   4  request vector, req[i] high while requester i wants the resource
//   gnt        out  4  one-hot grant, all zero when gnt_valid = 0
//   gnt_idx    out  2  index of current holder; holds last value when idle
//   gnt_valid  out  1  a grant is active this cycle
//   timeout    out  1  one-cycle pulse: the previous grant ended on MAX_HOLD
// ----------------------------------------------------------------------------
module rr_arbiter_4
    import arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    // Width holds 0..MAX_HOLD; the counter itself never passes MAX_HOLD-1.
    localparam int               CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t       state_q,     state_d;
    idx_t             ptr_q,       ptr_d;       // highest-priority requester
    logic [CNT_W-1:0] count_q,     count_d;     // cycles already spent in grant - 1
    idx_t             gnt_idx_q,   gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q,   timeout_d;

    // ------------------------------------------------------------------
    // Winner search: first requester at ptr, ptr+1, ... (mod 4).
    // Scanning offsets from the far end back towards ptr lets the nearest
    // requester overwrite any farther one, so the last hit is the winner.
    // ------------------------------------------------------------------
    idx_t win_idx;
    logic win_found;
    idx_t cand;

    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        cand      = ptr_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = idx_add(ptr_q, IDX_W'(k));
            if (req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant end detection
    // ------------------------------------------------------------------
    logic holder_req;
    logic at_limit;
    logic hold_end;

    assign holder_req = req[gnt_idx_q];
    assign at_limit   = (count_q == CNT_LAST);
    assign hold_end   = !ena || !holder_req || at_limit;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                gnt_valid_d = 1'b0;
                if (ena && win_found) begin
                    state_d     = S_GRANT;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    count_d     = '0;
                    ptr_d       = idx_add(win_idx, idx_t'(1));
                end
            end

            S_GRANT: begin
                if (!hold_end) begin
                    // Locked: other requests are ignored, ptr stays put.
                    count_d = count_q + CNT_W'(1);
                end else begin
                    // Only a limit-forced end while the holder still wants the
                    // resource counts as a timeout; a release or disable does not.
                    timeout_d = ena && holder_req && at_limit;
                    if (ena && win_found) begin
                        // Back-to-back handoff. ptr = holder+1 puts a timed-out
                        // holder last in the search, so it only wins if alone.
                        gnt_idx_d   = win_idx;
                        gnt_valid_d = 1'b1;
                        count_d     = '0;
                        ptr_d       = idx_add(win_idx, idx_t'(1));
                    end else begin
                        state_d     = S_IDLE;
                        gnt_valid_d = 1'b0;
                        count_d     = '0;
                    end
                end
            end

            default: begin
                state_d     = S_IDLE;
                gnt_valid_d = 1'b0;
                count_d     = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

    decoder_2_to_4 u_gnt_dec (
        .ena (gnt_valid_q),
        .in  (gnt_idx_q),
        .out (gnt)
    );

endmodule : rr_arbiter_4

// File: tb/tb_rr_arbiter_4.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter_4
//
// Directed bench for rr_arbiter_4 with MAX_HOLD = 8. Inputs are driven 1 time
// unit after each rising edge and outputs are checked at the same point, so
// each check sees the result of the edge just taken.
// ----------------------------------------------------------------------------
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    rr_arbiter_4 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_gnt,
                              input logic [1:0] e_idx, input logic e_valid,
                              input logic e_to);
        check({tag, ".gnt"},       8'(gnt),       8'(e_gnt));
        check({tag, ".gnt_idx"},   8'(gnt_idx),   8'(e_idx));
        check({tag, ".gnt_valid"}, 8'(gnt_valid), 8'(e_valid));
        check({tag, ".timeout"},   8'(timeout),   8'(e_to));
    endtask

    int         holders [5] = '{0, 1, 2, 3, 0};
    logic [3:0] lock_pat[5] = '{4'b1011, 4'b0111, 4'b1110, 4'b0011, 4'b1010};

    initial begin
        rst = 1'b0;
        ena = 1'b1;
        req = 4'b1111;

        // Reset held with every request high: nothing is granted.
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("reset[%0d]", i), 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        $display("step reset: held 3 cycles with req=1111");

        // Release reset; all four request forever -> 0,1,2,3,0, 8 cycles each,
        // timeout on the first cycle of every grant after the first.
        rst = 1'b1;
        for (int h = 0; h < 5; h++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                expect_out($sformatf("rot[h%0d c%0d]", h, c),
                           4'(1 << holders[h]), 2'(holders[h]), 1'b1,
                           (c == 0 && h > 0));
            end
            $display("step rotation: holder %0d for 8 cycles", holders[h]);
        end
        // Now: holder 0 at its last hold cycle, ptr = 1.

        // All requests drop -> idle, no timeout since holder released.
        req = 4'b0000;
        tick();
        expect_out("idle_after_rot", 4'b0000, 2'd0, 1'b0, 1'b0);
        $display("step release: all requests dropped");

        // ptr = 1, req = 1001 -> requester 3 wins; ptr becomes 0.
        req = 4'b1001;
        tick();
        expect_out("wrap_hold3_c0", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        expect_out("wrap_hold3_c1", 4'b1000, 2'd3, 1'b1, 1'b0);
        // Holder 3 releases -> wraps to requester 0 with no dead cycle.
        req = 4'b0001;
        tick();
        expect_out("wrap_to_0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("wrap_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        $display("step wrap: grant 3 -> 0 -> idle");

        // Sole requester 2 for 20 cycles: continuous grant, timeout at 8 and 16.
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_out($sformatf("sole[%0d]", i), 4'b0100, 2'd2, 1'b1,
                       (i == 8 || i == 16));
        end
        $display("step sole: requester 2 held 20 cycles");
        // Now: holder 2, ptr = 3.

        // Disable mid-grant -> grant dropped, index held.
        ena = 1'b0;
        tick();
        expect_out("ena_drop", 4'b0000, 2'd2, 1'b0, 1'b0);
        req = 4'b1111;
        tick();
        expect_out("ena_low_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        // Re-enable: search resumes at retained ptr = 3.
        ena = 1'b1;
        tick();
        expect_out("ena_resume", 4'b1000, 2'd3, 1'b1, 1'b0);
        $display("step enable: drop, hold, resume at ptr 3");

        // Holder 3 releases -> requester 1 wins (from ptr 0), ptr becomes 2.
        req = 4'b0110;
        tick();
        expect_out("pre_rst_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
        // Mid-grant reset -> everything cleared, ptr back to 0.
        rst = 1'b0;
        tick();
        expect_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        // ptr 0 -> requester 1; had ptr survived (2) it would be requester 2.
        expect_out("post_rst_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        $display("step mid-reset: cleared and regranted from ptr 0");

        // Lock: holder 1 keeps req high while others toggle.
        for (int i = 0; i < 5; i++) begin
            req = lock_pat[i];
            tick();
            expect_out($sformatf("lock[%0d]", i), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        // Holder 1 drops -> ptr 2 -> requester 2.
        req = 4'b1100;
        tick();
        expect_out("lock_release", 4'b0100, 2'd2, 1'b1, 1'b0);
        $display("step lock: holder 1 kept grant, handoff to 2 on release");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rr_arbiter_4
